unsi_divider_16bit: RTL and testbench

UNSI_DIVIDER_16BIT -- requirements
Module: unsi_divider_16bit

---
 rtl/unsi_divider_pkg.sv | 13 +
 rtl/unsi_div_step.sv | 19 +
 rtl/unsi_divider_16bit.sv | 111 +++++++++++
 tb/tb_unsi_divider_16bit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/unsi_divider_pkg.sv
// Shared widths and FSM state type for the 16-bit unsigned restoring divider.
package unsi_divider_pkg;

    localparam int DIV_WIDTH     = 16;
    localparam int DIV_LOG_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

endpackage

// File: rtl/unsi_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare, subtract.
module unsi_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // The extra top bit keeps the compare exact when the partial remainder's MSB is set.
    assign shifted = {rem_in, dividend_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/unsi_divider_16bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional divide-by-zero short-cut and error flag: define UNSI_DIV_ZERO_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start_division; operands captured on accept
// DIVIDE | WIDTH restoring steps, MSB first
// DONE   | output_ready high for this one cycle, then back to IDLE
module unsi_divider_16bit
    import unsi_divider_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter int LOG_WIDTH = DIV_LOG_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_division,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] output_Q,
    output logic [WIDTH-1:0] remainder,
    output logic             output_ready,
    output logic             error
);

    div_state_t           state;
    logic [LOG_WIDTH-1:0] count;
    logic [WIDTH-1:0]     dividend_r;
    logic [WIDTH-1:0]     divisor_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     step_rem;
    logic                 step_q;

`ifdef UNSI_DIV_ZERO_CHECK_EN
    logic error_r;
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    unsi_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem_r),
        .dividend_bit (dividend_r[WIDTH-1]),
        .divisor      (divisor_r),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // dividend_r doubles as the quotient: dividend bits leave at the top, quotient bits enter at the bottom.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            dividend_r   <= '0;
            divisor_r    <= '0;
            rem_r        <= '0;
            output_Q     <= '0;
            remainder    <= '0;
            output_ready <= 1'b0;
`ifdef UNSI_DIV_ZERO_CHECK_EN
            error_r      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    output_ready <= 1'b0;
                    if (start_division) begin
                        dividend_r <= input_1;
                        divisor_r  <= input_2;
                        rem_r      <= '0;
                        count      <= LOG_WIDTH'(WIDTH - 1);
`ifdef UNSI_DIV_ZERO_CHECK_EN
                        error_r    <= 1'b0;
                        if (input_2 == '0) begin
                            output_Q     <= '1;
                            remainder    <= input_1;
                            error_r      <= 1'b1;
                            output_ready <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= DIVIDE;
                        end
`else
                        state      <= DIVIDE;
`endif
                    end
                end
                DIVIDE: begin
                    rem_r      <= step_rem;
                    dividend_r <= {dividend_r[WIDTH-2:0], step_q};
                    if (count == '0) begin
                        output_Q     <= {dividend_r[WIDTH-2:0], step_q};
                        remainder    <= step_rem;
                        output_ready <= 1'b1;
                        state        <= DONE;
                    end else begin
                        count <= count - LOG_WIDTH'(1);
                    end
                end
                DONE: begin
                    output_ready <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    output_ready <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsi_divider_16bit.sv
// Self-checking bench for unsi_divider_16bit against an arithmetic reference model.
module tb_unsi_divider_16bit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_division = 1'b0;
    logic [15:0] input_1 = '0;
    logic [15:0] input_2 = '0;
    logic [15:0] output_Q;
    logic [15:0] remainder;
    logic        output_ready;
    logic        error;

    int checks = 0;
    int errors = 0;

`ifdef UNSI_DIV_ZERO_CHECK_EN
    localparam bit ZERO_CHECK = 1'b1;
`else
    localparam bit ZERO_CHECK = 1'b0;
`endif

    unsi_divider_16bit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start_division (start_division),
        .input_1        (input_1),
        .input_2        (input_2),
        .output_Q       (output_Q),
        .remainder      (remainder),
        .output_ready   (output_ready),
        .error          (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integer division, zero divisor per the configured behaviour.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic err, output int lat);
        if (b == 16'd0) begin
            q   = 16'hFFFF;
            r   = a;
            err = ZERO_CHECK;
            lat = ZERO_CHECK ? 0 : 16;
        end else begin
            q   = a / b;
            r   = a % b;
            err = 1'b0;
            lat = 16;
        end
    endtask

    task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        logic        ee;
        int          el, lat;
        bit          seen;
        ref_div(a, b, eq, er, ee, el);
        @(negedge clock);
        input_1        = a;
        input_2        = b;
        start_division = 1'b1;
        @(posedge clock);
        #1;
        start_division = 1'b0;
        input_1        = 16'($urandom);
        input_2        = 16'($urandom);
        lat  = 0;
        seen = output_ready;
        while (!seen && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            seen = output_ready;
        end
        chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_q"}, 32'(output_Q), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_err"}, 32'(error), 32'(ee));
        @(posedge clock);
        #1;
        chk({tag, "_ready_drop"}, 32'(output_ready), 32'd0);
        chk({tag, "_q_hold"}, 32'(output_Q), 32'(eq));
    endtask

    initial begin
        logic [15:0] eq, er;
        logic        ee;
        int          el, first_pulse, second_pulse, pulses;

        #12;
        chk("rst_q", 32'(output_Q), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_ready", 32'(output_ready), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        do_div("d100_5", 16'd100, 16'd5);
        do_div("d100_0", 16'd100, 16'd0);
        do_div("d0_5", 16'd0, 16'd5);
        do_div("d65535_256", 16'd65535, 16'd256);
        do_div("d10_20", 16'd10, 16'd20);
        do_div("d65535_1", 16'd65535, 16'd1);
        do_div("d1_65535", 16'd1, 16'd65535);
        do_div("d65535_32768", 16'd65535, 16'd32768);
        do_div("d65535_65535", 16'd65535, 16'd65535);

        // Reset mid-division: outputs clear, no ready pulse afterwards.
        @(negedge clock);
        input_1        = 16'd100;
        input_2        = 16'd5;
        start_division = 1'b1;
        @(posedge clock);
        #1;
        start_division = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(output_Q), 32'd0);
        chk("mid_rst_r", 32'(remainder), 32'd0);
        chk("mid_rst_ready", 32'(output_ready), 32'd0);
        chk("mid_rst_err", 32'(error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (output_ready) pulses++;
        end
        chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
        do_div("post_rst_100_5", 16'd100, 16'd5);

        // start_division held high: a second operation starts as IDLE is re-entered.
        @(negedge clock);
        input_1        = 16'd1000;
        input_2        = 16'd7;
        start_division = 1'b1;
        @(posedge clock);
        #1;
        first_pulse  = -1;
        second_pulse = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (output_ready) begin
                if (first_pulse < 0) first_pulse = i;
                else if (second_pulse < 0) second_pulse = i;
            end
            if (i == 20) start_division = 1'b0;
        end
        chk("held_first_pulse", 32'(first_pulse), 32'd16);
        chk("held_second_pulse", 32'(second_pulse), 32'd34);
        chk("held_q", 32'(output_Q), 32'd142);
        chk("held_r", 32'(remainder), 32'd6);

        for (int n = 0; n < 24; n++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            case (n % 4)
                0: b = 16'($urandom_range(1, 15));
                1: b = 16'($urandom);
                2: b = 16'($urandom_range(0, 1));
                default: b = 16'($urandom_range(1, 300));
            endcase
            ref_div(a, b, eq, er, ee, el);
            do_div($sformatf("rnd%0d", n), a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
